dmem_bus: RTL and testbench
===========================

DMEM_BUS -- requirements
Module: dmem_bus

Interface
REQ-001 Parameter ADDR_WIDTH, default 12: byte-address width.
REQ-002 Parameter MEM_SIZE, default 1024: bytes of storage; multiple of 4, at most 2^ADDR_WIDTH.
REQ-003 Parameter WAIT_STATES, default 1: extra access cycles, range 0..15.
REQ-004 One clock; reset is synchronous and active-high.
REQ-005 clk  input  1  clock; all state changes on rising edge.
REQ-006 rst  input  1  synchronous active-high reset.
REQ-007 req_valid  input  1  request present.
REQ-008 req_ready  output  1  block can accept a request.
REQ-009 req_write  input  1  1 = store, 0 = load.
REQ-010 req_addr  input  ADDR_WIDTH  byte address.
REQ-011 req_wdata  input  32  store data, LSB-aligned.
REQ-012 req_mode  input  3  000 B, 001 H, 010 W, 100 BU, 101 HU (RV32 funct3).
REQ-013 rsp_valid  output  1  response present.
REQ-014 rsp_ready  input  1  consumer accepts response.
REQ-015 rsp_rdata  output  32  load result; 0 for stores and errors.
REQ-016 rsp_err  output  1  request rejected, no side effect.

Function
REQ-017 Storage SHALL be MEM_SIZE bytes, little-endian; no reset of contents.
REQ-018 FSM states SHALL be IDLE, WAIT, ACCESS, RESP.
REQ-019 req_ready SHALL be 1 only in IDLE; rsp_valid SHALL be 1 only in RESP.
REQ-020 A request SHALL be accepted on a rising edge where req_valid and req_ready are both 1; addr, wdata, mode and write SHALL be latched there.
REQ-021 After acceptance, the FSM SHALL enter WAIT for WAIT_STATES cycles; when WAIT_STATES=0, it SHALL go directly to ACCESS.
REQ-022 ACCESS SHALL last one cycle, commit any store at its closing edge, register the load result, then enter RESP.
REQ-023 For acceptance in cycle k, rsp_valid SHALL first be 1 in cycle k+WAIT_STATES+2.
REQ-024 RESP SHALL hold rsp_valid, rsp_rdata and rsp_err stable until the edge with rsp_ready=1, then enter IDLE; no IDLE bypass, giving a throughput of one request per WAIT_STATES+3 cycles minimum.
REQ-025 Store widths: B writes byte addr; H writes addr..addr+1; W writes addr..addr+3; from wdata low bytes.
REQ-026 Store with mode BU or HU SHALL be an error.
REQ-027 Loads: B and H sign-extend to 32 bits; BU and HU zero-extend; W is unmodified.
REQ-028 Error conditions, each setting rsp_err=1, rsp_rdata=0 and leaving memory unchanged:
- mode 011, 110 or 111;
- H/HU with addr[0]=1;
- W with addr[1:0]≠0;
- addr+size-1 ≥ MEM_SIZE.
REQ-029 Errors SHALL still traverse WAIT/ACCESS/RESP with normal latency.
REQ-030 The WAIT counter SHALL be ceil(log2(WAIT_STATES+1)) bits wide, minimum 1, and SHALL not wrap.
REQ-031 rsp_rdata SHALL be 0 for successful stores; rsp_err SHALL be 0 for successful stores.

Reset
REQ-032 When rst=1, at the next edge the FSM SHALL enter IDLE with req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, and the WAIT counter at 0.
REQ-033 rst asserted in WAIT or ACCESS SHALL discard the request; a store SHALL not commit even in ACCESS.
REQ-034 rst asserted in RESP SHALL drop the response.
REQ-035 rst SHALL have priority over acceptance in the same cycle.

Verification (WAIT_STATES=1, MEM_SIZE=1024)
REQ-036 SW 0xDEADBEEF @0x010 accepted in cycle k -> rsp_valid in cycle k+3, err=0; then LW @0x010 -> 0xDEADBEEF.
REQ-037 After REQ-036, the following loads SHALL return:
- LB @0x013 -> 0xFFFFFFDE;
- LBU @0x013 -> 0x000000DE;
- LH @0x012 -> 0xFFFFDEAD;
- LHU @0x012 -> 0x0000DEAD.
REQ-038 SB 0x5A @0x011, then LW @0x010 -> 0xDEAD5AEF.
REQ-039 Each of the following SHALL return err=1, rdata=0:
- LW @0x012;
- SH @0x011;
- mode 011;
- LW @0x400;
- SBU @0x000.
LW @0x3FC -> err=0; memory SHALL be unchanged after every error case.
REQ-040 rsp_ready held 0 for 5 cycles in RESP -> rsp_valid, rsp_rdata and rsp_err stable and req_ready=0 throughout; IDLE the cycle after rsp_ready=1.
REQ-041 rst pulsed during ACCESS of SW 0x12345678 @0x020 (prior value 0x0BADF00D) -> IDLE next cycle, rsp_valid=0; LW @0x020 -> 0x0BADF00D.

Source files
------------

// File: rtl/dmem_bus.sv
// Byte-addressable little-endian data memory behind a valid/ready request/response
// handshake, with a configurable number of wait states before each access.
module dmem_bus #(
   parameter int ADDR_WIDTH  = 12,
   parameter int MEM_SIZE    = 1024,
   parameter int WAIT_STATES = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_write,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [31:0]           req_wdata,
   input  logic [2:0]            req_mode,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [31:0]           rsp_rdata,
   output logic                  rsp_err
);

   localparam int CNT_W = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
   localparam int IDX_W = $clog2(MEM_SIZE);
   localparam logic [CNT_W-1:0]  LAST_CNT  = CNT_W'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);
   localparam logic [ADDR_WIDTH:0] MEM_LIMIT = (ADDR_WIDTH + 1)'(MEM_SIZE);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS, S_RESP} state_t;

   state_t           state, state_nx;
   logic [CNT_W-1:0] cnt, cnt_nx;

   logic [7:0] mem [MEM_SIZE];

   logic                  write_p0;
   logic [ADDR_WIDTH-1:0] addr_p0;
   logic [31:0]           wdata_p0;
   logic [2:0]            mode_p0;

   logic [ADDR_WIDTH:0] span_p0;
   logic [ADDR_WIDTH:0] last_p0;
   logic                err_p0;
   logic [IDX_W-1:0]    idx0, idx1, idx2, idx3;
   logic [31:0]         raw_p0;

   // Sign/zero extension of a little-endian load word according to the RV32 funct3 code.
   function automatic logic [31:0] load_extend(input logic [31:0] raw, input logic [2:0] mode);
      logic signed [7:0]  b;
      logic signed [15:0] h;
      logic signed [31:0] s;
      b = raw[7:0];
      h = raw[15:0];
      case (mode)
         3'b000:  s = b;
         3'b001:  s = h;
         3'b100:  s = {24'd0, raw[7:0]};
         3'b101:  s = {16'd0, raw[15:0]};
         default: s = raw;
      endcase
      return s;
   endfunction

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
      end
   end

   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      unique case (state)
         S_IDLE: begin
            if (req_valid) begin
               cnt_nx   = '0;
               state_nx = (WAIT_STATES == 0) ? S_ACCESS : S_WAIT;
            end
         end
         S_WAIT: begin
            if (cnt == LAST_CNT) begin
               cnt_nx   = '0;
               state_nx = S_ACCESS;
            end else begin
               cnt_nx = cnt + 1'b1;
            end
         end
         S_ACCESS: state_nx = S_RESP;
         S_RESP:   if (rsp_ready) state_nx = S_IDLE;
         default:  state_nx = S_IDLE;
      endcase
   end

   always_comb begin
      req_ready = (state == S_IDLE);
      rsp_valid = (state == S_RESP);
   end

   // Request capture; rst keeps the FSM in IDLE, so a capture during reset is never used.
   always_ff @(posedge clk) begin
      if (state == S_IDLE && req_valid) begin
         write_p0 <= req_write;
         addr_p0  <= req_addr;
         wdata_p0 <= req_wdata;
         mode_p0  <= req_mode;
      end
   end

   always_comb begin
      case (mode_p0[1:0])
         2'b00:   span_p0 = (ADDR_WIDTH + 1)'(0);
         2'b01:   span_p0 = (ADDR_WIDTH + 1)'(1);
         default: span_p0 = (ADDR_WIDTH + 1)'(3);
      endcase
      last_p0 = {1'b0, addr_p0} + span_p0;
      err_p0  = (mode_p0 == 3'b011) || (mode_p0[2:1] == 2'b11)
             || ((mode_p0[1:0] == 2'b01) && addr_p0[0])
             || ((mode_p0[1:0] == 2'b10) && (addr_p0[1:0] != 2'b00))
             || (write_p0 && mode_p0[2])
             || (last_p0 >= MEM_LIMIT);
      idx0   = addr_p0[IDX_W-1:0];
      idx1   = idx0 + IDX_W'(1);
      idx2   = idx0 + IDX_W'(2);
      idx3   = idx0 + IDX_W'(3);
      raw_p0 = {mem[idx3], mem[idx2], mem[idx1], mem[idx0]};
   end

   // ACCESS stage: store commit at its closing edge, unless reset discards it.
   always_ff @(posedge clk) begin
      if (state == S_ACCESS && !rst && write_p0 && !err_p0) begin
         mem[idx0] <= wdata_p0[7:0];
         if (mode_p0[1:0] != 2'b00) mem[idx1] <= wdata_p0[15:8];
         if (mode_p0[1:0] == 2'b10) begin
            mem[idx2] <= wdata_p0[23:16];
            mem[idx3] <= wdata_p0[31:24];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
      end else if (state == S_ACCESS) begin
         rsp_err   <= err_p0;
         rsp_rdata <= (err_p0 || write_p0) ? 32'd0 : load_extend(raw_p0, mode_p0);
      end
   end

endmodule

// File: tb/tb_dmem_bus.sv
// Randomized self-checking bench for dmem_bus against a byte-array reference model.
module tb_dmem_bus;
   localparam int AW = 12;
   localparam int MS = 1024;
   localparam int WS = 1;

   logic          clk = 1'b0;
   logic          rst;
   logic          req_valid;
   logic          req_ready;
   logic          req_write;
   logic [AW-1:0] req_addr;
   logic [31:0]   req_wdata;
   logic [2:0]    req_mode;
   logic          rsp_valid;
   logic          rsp_ready;
   logic [31:0]   rsp_rdata;
   logic          rsp_err;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   logic [7:0] mm [MS];

   typedef struct packed {
      logic        w;
      logic [11:0] a;
      logic [31:0] d;
      logic [2:0]  m;
      logic [31:0] rd;
      logic        e;
      logic        cst;
   } vec_t;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   dmem_bus #(.ADDR_WIDTH(AW), .MEM_SIZE(MS), .WAIT_STATES(WS)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_mode(req_mode),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
   );

   // Reference: memory as a byte array, access rules as plain arithmetic.
   task automatic model_txn(input logic w, input int a, input logic [31:0] d, input logic [2:0] m,
                            output logic [31:0] er, output logic ee);
      int     size;
      longint v;
      size = (m[1:0] == 2'b00) ? 1 : (m[1:0] == 2'b01) ? 2 : 4;
      ee = (m == 3'd3) || (m == 3'd6) || (m == 3'd7) || (a % size != 0)
        || (a + size - 1 >= MS) || (w && m[2]);
      er = 32'd0;
      if (ee) return;
      if (w) begin
         for (int i = 0; i < size; i++) mm[a + i] = d[8*i +: 8];
      end else begin
         v = 0;
         for (int i = 0; i < size; i++) v += longint'(mm[a + i]) << (8 * i);
         if (!m[2] && size < 4 && v >= (longint'(1) << (8 * size - 1)))
            v -= (longint'(1) << (8 * size));
         er = 32'(v);
      end
   endtask

   task automatic do_txn(input logic w, input int a, input logic [31:0] d, input logic [2:0] m,
                         input int hold, output logic [31:0] rd, output logic e,
                         output int lat, output logic tmo);
      @(negedge clk);
      req_valid = 1'b1;
      req_write = w;
      req_addr  = AW'(a);
      req_wdata = d;
      req_mode  = m;
      rsp_ready = 1'b0;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      lat = 1;
      while (!rsp_valid && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      tmo = !rsp_valid;
      rd  = rsp_rdata;
      e   = rsp_err;
      repeat (hold) @(negedge clk);
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
   endtask

   function automatic vec_t dir_vec(input int i);
      case (i)
         0:  return '{1'b1, 12'h010, 32'hDEADBEEF, 3'b010, 32'h0,        1'b0, 1'b1};
         1:  return '{1'b0, 12'h010, 32'h0,        3'b010, 32'hDEADBEEF, 1'b0, 1'b1};
         2:  return '{1'b0, 12'h013, 32'h0,        3'b000, 32'hFFFFFFDE, 1'b0, 1'b1};
         3:  return '{1'b0, 12'h013, 32'h0,        3'b100, 32'h000000DE, 1'b0, 1'b1};
         4:  return '{1'b0, 12'h012, 32'h0,        3'b001, 32'hFFFFDEAD, 1'b0, 1'b1};
         5:  return '{1'b0, 12'h012, 32'h0,        3'b101, 32'h0000DEAD, 1'b0, 1'b1};
         6:  return '{1'b1, 12'h011, 32'h0000005A, 3'b000, 32'h0,        1'b0, 1'b1};
         7:  return '{1'b0, 12'h010, 32'h0,        3'b010, 32'hDEAD5AEF, 1'b0, 1'b1};
         8:  return '{1'b0, 12'h012, 32'h0,        3'b010, 32'h0,        1'b1, 1'b1};
         9:  return '{1'b1, 12'h011, 32'h0000FFFF, 3'b001, 32'h0,        1'b1, 1'b1};
         10: return '{1'b0, 12'h000, 32'h0,        3'b011, 32'h0,        1'b1, 1'b1};
         11: return '{1'b0, 12'h400, 32'h0,        3'b010, 32'h0,        1'b1, 1'b1};
         12: return '{1'b1, 12'h000, 32'h000000AA, 3'b100, 32'h0,        1'b1, 1'b1};
         13: return '{1'b0, 12'h3FC, 32'h0,        3'b010, 32'h0,        1'b0, 1'b0};
         14: return '{1'b0, 12'h010, 32'h0,        3'b010, 32'hDEAD5AEF, 1'b0, 1'b1};
         default: return '{1'b0, 12'h000, 32'h0,   3'b010, 32'h0,        1'b0, 1'b0};
      endcase
   endfunction

   task automatic test_reset();
      logic bad;
      rst = 1'b1;
      req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0; req_mode = 3'b010;
      rsp_ready = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready got %b exp 1", req_ready); end
      checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got %b exp 0", rsp_valid); end
      checks++; if (rsp_rdata !== 32'd0) begin errors++; $display("FAIL reset_rsp_rdata got %h exp 0", rsp_rdata); end
      checks++; if (rsp_err !== 1'b0) begin errors++; $display("FAIL reset_rsp_err got %b exp 0", rsp_err); end
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      req_valid = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      req_valid = 1'b0;
      bad = 1'b0;
      for (int i = 0; i < 6; i++) begin
         if (req_ready !== 1'b1 || rsp_valid !== 1'b0) bad = 1'b1;
         @(negedge clk);
      end
      checks++; if (bad) begin errors++; $display("FAIL reset_priority got accepted exp ignored"); end
   endtask

   task automatic init_mem();
      logic [31:0] rd, er, d;
      logic e, ee, tmo;
      int lat, nbad;
      nbad = 0;
      for (int a = 0; a < MS; a += 4) begin
         d = $urandom;
         do_txn(1'b1, a, d, 3'b010, 0, rd, e, lat, tmo);
         model_txn(1'b1, a, d, 3'b010, er, ee);
         if (tmo || e !== 1'b0) nbad++;
      end
      checks++; if (nbad != 0) begin errors++; $display("FAIL init_stores got %0d bad exp 0", nbad); end
   endtask

   task automatic test_directed();
      vec_t v;
      logic [31:0] rd, er, exp_rd;
      logic e, ee, tmo;
      int lat;
      for (int i = 0; i < 16; i++) begin
         v = dir_vec(i);
         if (i == 15) v.a = 12'h000;
         do_txn(v.w, int'(v.a), v.d, v.m, 0, rd, e, lat, tmo);
         model_txn(v.w, int'(v.a), v.d, v.m, er, ee);
         exp_rd = v.cst ? v.rd : er;
         checks++; if (tmo || lat != WS + 2) begin errors++; $display("FAIL dir%0d_latency got %0d exp %0d", i, lat, WS + 2); end
         checks++; if (rd !== exp_rd) begin errors++; $display("FAIL dir%0d_rdata got %h exp %h", i, rd, exp_rd); end
         checks++; if (e !== v.e) begin errors++; $display("FAIL dir%0d_err got %b exp %b", i, e, v.e); end
      end
   endtask

   task automatic test_random();
      logic [31:0] rd, er, d;
      logic e, ee, tmo, w;
      logic [2:0] m;
      int a, r, lat;
      for (int i = 0; i < 300; i++) begin
         r = $urandom_range(0, 9);
         if (r < 7)      a = $urandom_range(0, MS - 1);
         else if (r < 9) a = $urandom_range(MS - 8, MS + 7);
         else            a = $urandom_range(0, (1 << AW) - 1);
         m = 3'($urandom_range(0, 7));
         w = 1'($urandom_range(0, 1));
         d = $urandom;
         do_txn(w, a, d, m, $urandom_range(0, 2), rd, e, lat, tmo);
         model_txn(w, a, d, m, er, ee);
         checks++; if (tmo || lat != WS + 2) begin errors++; $display("FAIL rnd%0d_latency got %0d exp %0d", i, lat, WS + 2); end
         checks++; if (rd !== er) begin errors++; $display("FAIL rnd%0d_rdata a=%h m=%0d w=%b got %h exp %h", i, a, m, w, rd, er); end
         checks++; if (e !== ee) begin errors++; $display("FAIL rnd%0d_err a=%h m=%0d w=%b got %b exp %b", i, a, m, w, e, ee); end
      end
   endtask

   task automatic test_backpressure();
      logic [31:0] er;
      logic ee, bad;
      int n;
      model_txn(1'b0, 'h10, 32'd0, 3'b010, er, ee);
      @(negedge clk);
      req_valid = 1'b1; req_write = 1'b0; req_addr = AW'('h10); req_mode = 3'b010;
      rsp_ready = 1'b0;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      n = 0;
      while (!rsp_valid && n < 20) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (!rsp_valid) begin
         errors++; $display("FAIL bp_timeout got no rsp_valid exp rsp_valid");
      end
      bad = 1'b0;
      for (int i = 0; i < 5; i++) begin
         if (rsp_valid !== 1'b1 || rsp_rdata !== er || rsp_err !== 1'b0 || req_ready !== 1'b0) bad = 1'b1;
         @(negedge clk);
      end
      checks++; if (bad) begin errors++; $display("FAIL bp_hold got unstable rdata=%h exp %h", rsp_rdata, er); end
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      checks++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
         errors++; $display("FAIL bp_release got ready=%b valid=%b exp 1 0", req_ready, rsp_valid);
      end
   endtask

   task automatic test_reset_access();
      logic [31:0] rd, er;
      logic e, ee, tmo, bad;
      int lat;
      do_txn(1'b1, 'h20, 32'h0BADF00D, 3'b010, 0, rd, e, lat, tmo);
      model_txn(1'b1, 'h20, 32'h0BADF00D, 3'b010, er, ee);
      @(negedge clk);
      req_valid = 1'b1; req_write = 1'b1; req_addr = AW'('h20); req_wdata = 32'h12345678; req_mode = 3'b010;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checks++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_rdata !== 32'd0) begin
         errors++; $display("FAIL rst_access_idle got ready=%b valid=%b rdata=%h exp 1 0 0", req_ready, rsp_valid, rsp_rdata);
      end
      bad = 1'b0;
      for (int i = 0; i < 4; i++) begin
         if (rsp_valid !== 1'b0) bad = 1'b1;
         @(negedge clk);
      end
      checks++; if (bad) begin errors++; $display("FAIL rst_access_drop got rsp_valid exp none"); end
      do_txn(1'b0, 'h20, 32'd0, 3'b010, 0, rd, e, lat, tmo);
      checks++; if (tmo || rd !== 32'h0BADF00D || e !== 1'b0) begin
         errors++; $display("FAIL rst_access_mem got %h err=%b exp 0badf00d err=0", rd, e);
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] er;
      logic ee;
      int acc [4];
      int na, bad_rd;
      model_txn(1'b0, 'h3FC, 32'd0, 3'b010, er, ee);
      @(negedge clk);
      req_valid = 1'b1; req_write = 1'b0; req_addr = AW'('h3FC); req_mode = 3'b010;
      rsp_ready = 1'b1;
      na = 0;
      bad_rd = 0;
      for (int i = 0; i < 40 && na < 4; i++) begin
         if (rsp_valid === 1'b1 && rsp_rdata !== er) bad_rd++;
         if (req_ready === 1'b1) begin
            acc[na] = cyc;
            na++;
         end
         if (na < 4) @(negedge clk);
      end
      req_valid = 1'b0;
      for (int i = 0; i < 20 && req_ready !== 1'b1; i++) @(negedge clk);
      repeat (2) @(negedge clk);
      rsp_ready = 1'b0;
      checks++; if (na != 4) begin errors++; $display("FAIL b2b_count got %0d exp 4", na); end
      checks++; if (bad_rd != 0) begin errors++; $display("FAIL b2b_rdata got %0d bad exp 0", bad_rd); end
      for (int i = 1; i < na; i++) begin
         checks++; if (acc[i] - acc[i-1] != WS + 3) begin
            errors++; $display("FAIL b2b_gap%0d got %0d exp %0d", i, acc[i] - acc[i-1], WS + 3);
         end
      end
   endtask

   initial begin
      test_reset();
      init_mem();
      test_directed();
      test_random();
      test_backpressure();
      test_reset_access();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog got timeout exp completion");
      $fatal(1, "watchdog");
   end

endmodule
